// File: rtl/mips32_pkg.sv
// Shared definitions for the pipelined MIPS32-subset core: opcodes, instruction classes,
// ALU operations, pipeline-register layouts and opcode decode helpers.
package mips32_pkg;

   localparam int MEM_WORDS_DEFAULT = 1024;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_class_t;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_t;

   // dest is zero for every instruction that does not write the register file
   typedef struct packed {
      logic        valid;
      logic [31:0] ir;
      logic [31:0] npc;
   } if_id_t;

   typedef struct packed {
      logic         valid;
      instr_class_t cls;
      alu_op_t      alu_op;
      logic         bz;
      logic [4:0]   rs;
      logic [4:0]   rt;
      logic [4:0]   dest;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  imm;
      logic [31:0]  npc;
   } id_ex_t;

   typedef struct packed {
      logic         valid;
      instr_class_t cls;
      logic [4:0]   dest;
      logic [31:0]  alu_out;
      logic [31:0]  b;
   } ex_mem_t;

   typedef struct packed {
      logic         valid;
      instr_class_t cls;
      logic [4:0]   dest;
      logic [31:0]  result;
   } mem_wb_t;

   function automatic instr_class_t decode_class(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: decode_class = RR_ALU;
         OP_ADDI, OP_SUBI, OP_SLTI:                     decode_class = RM_ALU;
         OP_LW:                                         decode_class = LOAD;
         OP_SW:                                         decode_class = STORE;
         OP_BNEQZ, OP_BEQZ:                             decode_class = BRANCH;
         OP_HLT:                                        decode_class = HALT;
         default:                                       decode_class = NOP;
      endcase
   endfunction

   // Loads and stores use ADD to form rs+imm
   function automatic alu_op_t decode_alu(input logic [5:0] op);
      case (op)
         OP_SUB, OP_SUBI: decode_alu = ALU_SUB;
         OP_AND:          decode_alu = ALU_AND;
         OP_OR:           decode_alu = ALU_OR;
         OP_SLT, OP_SLTI: decode_alu = ALU_SLT;
         OP_MUL:          decode_alu = ALU_MUL;
         default:         decode_alu = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational 32-bit ALU: wrapping add/sub, bitwise and/or, signed set-less-than,
// and the low 32 bits of a multiply.
module mips32_alu
   import mips32_pkg::*;
(
   input  alu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_MUL: y = a * b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/pipe_mips32_core.sv
// Five-stage in-order MIPS32-subset core with unified word memory, EX-stage forwarding,
// EX-resolved branches (two-cycle flush) and a halt that freezes all state once HLT reaches WB.
module pipe_mips32_core
   import mips32_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
   parameter int NREGS     = 32
) (
   input  logic clk1,
   input  logic rst,
   output logic halted
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0] Reg [0:NREGS-1];
   logic [31:0] Mem [0:MEM_WORDS-1];
   logic [31:0] PC;
   logic        HALTED;
   logic        TAKEN_BRANCH;

   if_id_t  if_id;
   id_ex_t  id_ex,  id_next;
   ex_mem_t ex_mem, ex_next;
   mem_wb_t mem_wb, mem_next;

   logic          freeze;
   logic          wb_we;
   logic [31:0]   if_ir;
   logic [5:0]    id_op;
   logic [4:0]    id_rs, id_rt, id_rd;
   instr_class_t  id_cls;
   logic [31:0]   rf_a, rf_b;
   logic [31:0]   ex_a, ex_b, ex_alu_b, ex_y;
   logic          ex_taken;
   logic [AW-1:0] mem_addr;
   logic          mem_we;

   // Once HLT sits in WB nothing younger may commit; HALTED then holds everything.
   assign freeze = HALTED | (mem_wb.valid && mem_wb.cls == HALT);
   assign halted = HALTED;
   assign wb_we  = mem_wb.valid && (mem_wb.dest != 5'd0) && !freeze;

   // ---------------- IF / ID ----------------
   assign if_ir  = Mem[PC[AW-1:0]];
   assign id_op  = if_id.ir[31:26];
   assign id_rs  = if_id.ir[25:21];
   assign id_rt  = if_id.ir[20:16];
   assign id_rd  = if_id.ir[15:11];
   assign id_cls = decode_class(id_op);

   // Write-through read: a same-cycle WB write is visible to the ID read.
   always_comb begin
      rf_a = Reg[id_rs];
      rf_b = Reg[id_rt];
      if (wb_we && mem_wb.dest == id_rs) rf_a = mem_wb.result;
      if (wb_we && mem_wb.dest == id_rt) rf_b = mem_wb.result;
      if (id_rs == 5'd0) rf_a = '0;
      if (id_rt == 5'd0) rf_b = '0;
   end

   always_comb begin
      id_next        = '0;
      id_next.valid  = if_id.valid;
      id_next.cls    = id_cls;
      id_next.alu_op = decode_alu(id_op);
      id_next.bz     = (id_op == OP_BEQZ);
      id_next.rs     = id_rs;
      id_next.rt     = id_rt;
      id_next.a      = rf_a;
      id_next.b      = rf_b;
      id_next.imm    = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
      id_next.npc    = if_id.npc;
      case (id_cls)
         RR_ALU:       id_next.dest = id_rd;
         RM_ALU, LOAD: id_next.dest = id_rt;
         default:      id_next.dest = 5'd0;
      endcase
   end

   // ---------------- EX ----------------
   // A load result is not ready in EX/MEM, so only MEM/WB may forward it.
   always_comb begin
      ex_a = id_ex.a;
      ex_b = id_ex.b;
      if (mem_wb.valid && mem_wb.dest != 5'd0 && mem_wb.dest == id_ex.rs) ex_a = mem_wb.result;
      if (mem_wb.valid && mem_wb.dest != 5'd0 && mem_wb.dest == id_ex.rt) ex_b = mem_wb.result;
      if (ex_mem.valid && ex_mem.dest != 5'd0 && ex_mem.cls != LOAD && ex_mem.dest == id_ex.rs)
         ex_a = ex_mem.alu_out;
      if (ex_mem.valid && ex_mem.dest != 5'd0 && ex_mem.cls != LOAD && ex_mem.dest == id_ex.rt)
         ex_b = ex_mem.alu_out;
   end

   assign ex_alu_b = (id_ex.cls == RR_ALU) ? ex_b : id_ex.imm;
   assign ex_taken = id_ex.valid && (id_ex.cls == BRANCH) &&
                     (id_ex.bz ? (ex_a == 32'd0) : (ex_a != 32'd0));

   mips32_alu u_alu (
      .op (id_ex.alu_op),
      .a  (ex_a),
      .b  (ex_alu_b),
      .y  (ex_y)
   );

   always_comb begin
      ex_next         = '0;
      ex_next.valid   = id_ex.valid;
      ex_next.cls     = id_ex.cls;
      ex_next.dest    = id_ex.dest;
      ex_next.alu_out = ex_y;
      ex_next.b       = ex_b;
   end

   // ---------------- MEM ----------------
   assign mem_addr = ex_mem.alu_out[AW-1:0];
   assign mem_we   = ex_mem.valid && (ex_mem.cls == STORE) && !freeze;

   always_comb begin
      mem_next        = '0;
      mem_next.valid  = ex_mem.valid;
      mem_next.cls    = ex_mem.cls;
      mem_next.dest   = ex_mem.dest;
      mem_next.result = (ex_mem.cls == LOAD) ? Mem[mem_addr] : ex_mem.alu_out;
   end

   // ---------------- state ----------------
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         PC           <= '0;
         HALTED       <= 1'b0;
         TAKEN_BRANCH <= 1'b0;
         if_id        <= '0;
         id_ex        <= '0;
         ex_mem       <= '0;
         mem_wb       <= '0;
      end else if (freeze) begin
         HALTED       <= 1'b1;
         TAKEN_BRANCH <= 1'b0;
      end else begin
         TAKEN_BRANCH <= ex_taken;
         if (ex_taken) begin
            PC    <= id_ex.npc + id_ex.imm;
            if_id <= '0;
            id_ex <= '0;
         end else begin
            PC    <= PC + 32'd1;
            if_id <= '{valid: 1'b1, ir: if_ir, npc: PC + 32'd1};
            id_ex <= id_next;
         end
         ex_mem <= ex_next;
         mem_wb <= mem_next;
      end
   end

   // Architectural storage is never reset; bubbles carry no write enables.
   always_ff @(posedge clk1) begin
      if (mem_we) Mem[mem_addr] <= ex_mem.b;
      if (wb_we)  Reg[mem_wb.dest] <= mem_wb.result;
   end

endmodule

// File: tb/tb_pipe_mips32_core.sv
// Bench for pipe_mips32_core: directed programs plus random programs checked against a
// sequential instruction-level interpreter of the same ISA.
module tb_pipe_mips32_core;

   logic clk1 = 1'b0;
   logic rst  = 1'b1;
   logic halted;

   pipe_mips32_core dut (
      .clk1   (clk1),
      .rst    (rst),
      .halted (halted)
   );

   always #5 clk1 = ~clk1;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          taken_cnt;
   logic [31:0] m_reg [0:31];
   logic [31:0] m_mem [0:1023];
   logic [31:0] prog [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic init_image();
      for (int i = 0; i < 1024; i++) m_mem[10'(i)] = 32'd0;
      for (int k = 0; k < 32; k++) m_reg[5'(k)] = 32'(k);
   endtask

   task automatic put_prog();
      for (int i = 0; i < prog.size(); i++) m_mem[10'(i)] = prog[i];
   endtask

   // Sequential ISA interpreter: one instruction per step, no pipeline notion.
   task automatic model_run(output int execd, output int taken, output logic [31:0] hlt_pc);
      logic [31:0] pc, ir, a, b, imm, val, addr;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, dst;
      bit          wr, stop;
      pc = 0; execd = 0; taken = 0; stop = 0; hlt_pc = 0;
      while (!stop && execd < 5000) begin
         ir   = m_mem[pc[9:0]];
         op   = ir[31:26];
         rs   = ir[25:21];
         rt   = ir[20:16];
         rd   = ir[15:11];
         imm  = {{16{ir[15]}}, ir[15:0]};
         a    = (rs == 5'd0) ? 32'd0 : m_reg[rs];
         b    = (rt == 5'd0) ? 32'd0 : m_reg[rt];
         addr = a + imm;
         wr   = 0; dst = 5'd0; val = 32'd0;
         execd++;
         pc = pc + 32'd1;
         case (op)
            6'h00: begin wr = 1; dst = rd; val = a + b; end
            6'h01: begin wr = 1; dst = rd; val = a - b; end
            6'h02: begin wr = 1; dst = rd; val = a & b; end
            6'h03: begin wr = 1; dst = rd; val = a | b; end
            6'h04: begin wr = 1; dst = rd; val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            6'h05: begin wr = 1; dst = rd; val = a * b; end
            6'h08: begin wr = 1; dst = rt; val = m_mem[addr[9:0]]; end
            6'h09: m_mem[addr[9:0]] = b;
            6'h0a: begin wr = 1; dst = rt; val = a + imm; end
            6'h0b: begin wr = 1; dst = rt; val = a - imm; end
            6'h0c: begin wr = 1; dst = rt; val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; end
            6'h0d: if (a != 32'd0) begin pc = pc + imm; taken++; end
            6'h0e: if (a == 32'd0) begin pc = pc + imm; taken++; end
            6'h3f: begin stop = 1; hlt_pc = pc - 32'd1; end
            default: ;
         endcase
         if (wr && dst != 5'd0) m_reg[dst] = val;
      end
   endtask

   task automatic apply_reset(input bit preload);
      @(negedge clk1);
      rst = 1'b1;
      if (preload) begin
         for (int k = 0; k < 32; k++) dut.Reg[5'(k)] <= m_reg[5'(k)];
         for (int i = 0; i < 1024; i++) dut.Mem[10'(i)] <= m_mem[10'(i)];
      end
      @(negedge clk1);
   endtask

   task automatic run_dut(output int cycles);
      bit done;
      done = 0;
      @(negedge clk1);
      rst = 1'b0;
      cycles = 0;
      taken_cnt = 0;
      while (!done && cycles < 3000) begin
         @(posedge clk1);
         #1;
         cycles++;
         if (dut.TAKEN_BRANCH) taken_cnt++;
         if (halted) done = 1;
      end
      check_eq("halted_after_run", {31'b0, halted}, 32'd1);
   endtask

   task automatic compare_state(input string tag, input logic [31:0] hlt_pc);
      for (int k = 0; k < 32; k++)
         check_eq($sformatf("%s r%0d", tag, k), dut.Reg[5'(k)], m_reg[5'(k)]);
      for (int i = 512; i < 576; i++)
         check_eq($sformatf("%s mem%0d", tag, i), dut.Mem[10'(i)], m_mem[10'(i)]);
      check_eq({tag, " pc"}, dut.PC, hlt_pc + 32'd4);
   endtask

   task automatic gen_random();
      int n, kind;
      init_image();
      m_reg[1] = 32'd512;
      for (int k = 2; k < 32; k++) m_reg[5'(k)] = $urandom();
      for (int i = 512; i < 576; i++) m_mem[10'(i)] = $urandom();
      prog.delete();
      n = $urandom_range(20, 40);
      while (prog.size() < n) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2, 3: prog.push_back(enc_r(6'($urandom_range(0, 5)), 5'($urandom_range(0, 15)),
                                              5'($urandom_range(0, 15)), 5'($urandom_range(2, 15))));
            4, 5: prog.push_back(enc_i(6'($urandom_range(10, 12)), 5'($urandom_range(0, 15)),
                                       5'($urandom_range(2, 15)), 16'($urandom())));
            6: begin
               prog.push_back(enc_i(6'h08, 5'd1, 5'($urandom_range(2, 15)), 16'($urandom_range(0, 63))));
               prog.push_back(32'h4000_0000);
            end
            7: prog.push_back(enc_i(6'h09, 5'd1, 5'($urandom_range(0, 15)), 16'($urandom_range(0, 63))));
            8: prog.push_back(enc_i(6'($urandom_range(13, 14)), 5'($urandom_range(0, 15)), 5'd0,
                                    16'($urandom_range(0, 3))));
            default: prog.push_back({6'($urandom_range(16, 31)), 26'($urandom())});
         endcase
      end
      repeat (5) prog.push_back(32'hfc00_0000);
      put_prog();
   endtask

   initial begin
      int          cyc, ex, tk;
      logic [31:0] hp;

      // ---- factorial, reset state ----
      init_image();
      prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000, 32'h14431000,
               32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe, 32'hfc000000};
      put_prog();
      m_mem[200] = 32'd8;
      apply_reset(1);
      check_eq("reset halted", {31'b0, halted}, 32'd0);
      check_eq("reset pc", dut.PC, 32'd0);
      check_eq("reset taken", {31'b0, dut.TAKEN_BRANCH}, 32'd0);
      model_run(ex, tk, hp);
      run_dut(cyc);
      check_eq("fact cycles", 32'(cyc), 32'(ex + 4 + 2 * tk));
      check_eq("fact mem198", dut.Mem[198], 32'd40320);
      check_eq("fact mem200", dut.Mem[200], 32'd8);
      check_eq("fact r3", dut.Reg[3], 32'd0);
      check_eq("fact r2", dut.Reg[2], 32'd40320);
      check_eq("fact taken pulses", 32'(taken_cnt), 32'd7);

      // ---- freeze after halt ----
      repeat (20) @(posedge clk1);
      #1;
      compare_state("freeze", hp);
      check_eq("freeze mem198", dut.Mem[198], 32'd40320);
      check_eq("freeze halted", {31'b0, halted}, 32'd1);

      // ---- asynchronous reset mid-cycle, then rerun without reloading ----
      @(posedge clk1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async rst halted", {31'b0, halted}, 32'd0);
      check_eq("async rst pc", dut.PC, 32'd0);
      run_dut(cyc);
      check_eq("rerun cycles", 32'(cyc), 32'(ex + 4 + 2 * tk));
      check_eq("rerun mem198", dut.Mem[198], 32'd40320);
      check_eq("rerun r2", dut.Reg[2], 32'd40320);
      check_eq("rerun r3", dut.Reg[3], 32'd0);

      // ---- back-to-back ALU hazards ----
      init_image();
      prog = '{enc_i(6'h0a, 5'd0, 5'd1, 16'd10), enc_i(6'h0a, 5'd0, 5'd2, 16'd20),
               enc_r(6'h00, 5'd1, 5'd2, 5'd3), enc_r(6'h00, 5'd3, 5'd3, 5'd4), 32'hfc000000};
      put_prog();
      apply_reset(1);
      run_dut(cyc);
      check_eq("b2b r3", dut.Reg[3], 32'd30);
      check_eq("b2b r4", dut.Reg[4], 32'd60);
      check_eq("b2b cycles", 32'(cyc), 32'd9);

      // ---- load / store with one-instruction gap ----
      init_image();
      m_mem[120] = 32'd85;
      m_reg[1]   = 32'd120;
      prog = '{enc_i(6'h08, 5'd1, 5'd2, 16'd0), enc_r(6'h03, 5'd20, 5'd20, 5'd20),
               enc_i(6'h0a, 5'd2, 5'd2, 16'd45), enc_i(6'h09, 5'd1, 5'd2, 16'd1), 32'hfc000000};
      put_prog();
      apply_reset(1);
      run_dut(cyc);
      check_eq("ls mem121", dut.Mem[121], 32'd130);
      check_eq("ls r2", dut.Reg[2], 32'd130);
      check_eq("ls mem120", dut.Mem[120], 32'd85);

      // ---- branch squash ----
      init_image();
      prog = '{enc_i(6'h0e, 5'd0, 5'd0, 16'd2), enc_i(6'h0a, 5'd0, 5'd5, 16'd1),
               enc_i(6'h0a, 5'd0, 5'd6, 16'd1), enc_i(6'h0a, 5'd0, 5'd7, 16'd7), 32'hfc000000};
      put_prog();
      apply_reset(1);
      run_dut(cyc);
      check_eq("br r5", dut.Reg[5], 32'd5);
      check_eq("br r6", dut.Reg[6], 32'd6);
      check_eq("br r7", dut.Reg[7], 32'd7);
      check_eq("br taken pulses", 32'(taken_cnt), 32'd1);
      check_eq("br cycles", 32'(cyc), 32'd9);

      // ---- R0, signed SLT, undefined opcode ----
      init_image();
      m_reg[2] = 32'hffff_ffff;
      m_reg[3] = 32'd1;
      prog = '{enc_i(6'h0a, 5'd0, 5'd0, 16'd5), enc_r(6'h04, 5'd2, 5'd3, 5'd1),
               32'h43ff_ffff, 32'hfc000000};
      put_prog();
      apply_reset(1);
      run_dut(cyc);
      check_eq("misc r0", dut.Reg[0], 32'd0);
      check_eq("misc slt r1", dut.Reg[1], 32'd1);
      check_eq("misc undef r31", dut.Reg[31], 32'd31);
      check_eq("misc undef mem1023", dut.Mem[1023], 32'd0);
      check_eq("misc cycles", 32'(cyc), 32'd8);

      // ---- random programs against the interpreter ----
      for (int t = 0; t < 20; t++) begin
         gen_random();
         apply_reset(1);
         model_run(ex, tk, hp);
         run_dut(cyc);
         check_eq($sformatf("rnd%0d cycles", t), 32'(cyc), 32'(ex + 4 + 2 * tk));
         check_eq($sformatf("rnd%0d taken", t), 32'(taken_cnt), 32'(tk));
         compare_state($sformatf("rnd%0d", t), hp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
